// File: rtl/pwm_audio_pkg.sv
// Shared constants and sizing helpers for the multi-channel PWM / sigma-delta audio back-end.
package pwm_audio_pkg;

   localparam logic MODE_PWM = 1'b0;
   localparam logic MODE_SD  = 1'b1;

   // Mixer width: wide enough that the sum of all channels at full scale cannot overflow.
   function automatic int mix_w(input int channels, input int sample_w);
      return sample_w + $clog2(channels);
   endfunction

endpackage

// File: rtl/pwm_audio_chan.sv
// One input channel: a single-entry holding register behind valid/ready, the sample
// currently playing (last), and a sticky underrun flag updated at each frame boundary.
module pwm_audio_chan
#(
   parameter int SAMPLE_W = 8
)
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [SAMPLE_W-1:0] data_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic                boundary_i,
   input  logic                underrun_clr_i,
   output logic [SAMPLE_W-1:0] next_last_o,
   output logic                underrun_o
);

   logic                full_q;
   logic                full_d;
   logic                und_q;
   logic                und_d;
   logic [SAMPLE_W-1:0] held_q;
   logic [SAMPLE_W-1:0] held_d;
   logic [SAMPLE_W-1:0] last_q;
   logic [SAMPLE_W-1:0] last_d;
   logic                xfer_s;

   assign ready_o     = ~full_q & ~rst_i;
   assign xfer_s      = valid_i & ready_o;
   assign next_last_o = full_q ? held_q : last_q;
   assign underrun_o  = und_q;

   // Boundary promotion of the held sample, new-sample capture and underrun bookkeeping
   always_comb begin
      full_d = full_q;
      held_d = held_q;
      last_d = last_q;
      und_d  = und_q;
      if (boundary_i && full_q) begin
         last_d = held_q;
         full_d = 1'b0;
      end else begin
         last_d = last_q;
      end
      // A sample captured on the boundary edge itself lands only for the following frame.
      if (xfer_s) begin
         held_d = data_i;
         full_d = 1'b1;
      end else begin
         held_d = held_q;
      end
      if (boundary_i && !full_q) begin
         und_d = 1'b1;
      end else if (underrun_clr_i) begin
         und_d = 1'b0;
      end else begin
         und_d = und_q;
      end
   end

   // Channel state registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         full_q <= 1'b0;
         held_q <= {SAMPLE_W{1'b0}};
         last_q <= {SAMPLE_W{1'b0}};
         und_q  <= 1'b0;
      end else begin
         full_q <= full_d;
         held_q <= held_d;
         last_q <= last_d;
         und_q  <= und_d;
      end
   end

endmodule

// File: rtl/pwm_audio_mixer.sv
// Multi-channel audio DAC back-end: sums per-channel samples once per frame and drives
// a single pin as edge-aligned PWM or first-order sigma-delta.
module pwm_audio_mixer
   import pwm_audio_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int SAMPLE_W = 8
)
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [CHANNELS*SAMPLE_W-1:0] in_data,
   input  logic [CHANNELS-1:0]          in_valid,
   output logic [CHANNELS-1:0]          in_ready,
   input  logic                         mode,
   input  logic                         mute,
   input  logic                         underrun_clr,
   output logic [CHANNELS-1:0]          underrun,
   output logic                         frame_strobe,
   output logic                         pwm
);

   localparam int               MIX_W   = mix_w(CHANNELS, SAMPLE_W);
   localparam logic [MIX_W-1:0] CNT_MAX = {MIX_W{1'b1}};

   logic [MIX_W-1:0]    cnt_q;
   logic [MIX_W-1:0]    cnt_d;
   logic [MIX_W-1:0]    duty_q;
   logic [MIX_W-1:0]    duty_d;
   logic [MIX_W-1:0]    acc_q;
   logic [MIX_W-1:0]    acc_d;
   logic [MIX_W-1:0]    sum_s;
   logic [MIX_W-1:0]    acc_sum_s;
   logic                carry_s;
   logic                mode_q;
   logic                mode_d;
   logic                pwm_q;
   logic                pwm_d;
   logic                strobe_q;
   logic                strobe_d;
   logic                boundary_s;
   logic [SAMPLE_W-1:0] next_last_s [CHANNELS];

   assign boundary_s   = (cnt_q == CNT_MAX);
   assign frame_strobe = strobe_q;
   assign pwm          = pwm_q;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      pwm_audio_chan #(
         .SAMPLE_W (SAMPLE_W)
      ) u_chan (
         .clk_i          (clk),
         .rst_i          (rst),
         .data_i         (in_data[c*SAMPLE_W +: SAMPLE_W]),
         .valid_i        (in_valid[c]),
         .ready_o        (in_ready[c]),
         .boundary_i     (boundary_s),
         .underrun_clr_i (underrun_clr),
         .next_last_o    (next_last_s[c]),
         .underrun_o     (underrun[c])
      );
   end

   // Adder tree over the samples that will play in the coming frame
   always_comb begin
      sum_s = {MIX_W{1'b0}};
      for (int c = 0; c < CHANNELS; c++) begin
         sum_s = sum_s + MIX_W'(next_last_s[c]);
      end
   end

   // Frame counter, boundary capture of duty/mode, and the output modulator
   always_comb begin
      cnt_d  = cnt_q + MIX_W'(1);
      duty_d = duty_q;
      mode_d = mode_q;
      if (boundary_s) begin
         duty_d = mute ? {MIX_W{1'b0}} : sum_s;
         mode_d = mode;
      end else begin
         duty_d = duty_q;
         mode_d = mode_q;
      end
      // New duty and mode take effect on the very edge that starts the frame.
      {carry_s, acc_sum_s} = {1'b0, acc_q} + {1'b0, duty_d};
      acc_d = acc_q;
      pwm_d = 1'b0;
      case (mode_d)
         MODE_PWM: begin
            acc_d = acc_q;
            pwm_d = (cnt_d < duty_d);
         end
         MODE_SD: begin
            acc_d = acc_sum_s;
            pwm_d = carry_s;
         end
         default: begin
            acc_d = acc_q;
            pwm_d = 1'b0;
         end
      endcase
      strobe_d = (cnt_d == CNT_MAX);
   end

   // Top-level state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= {MIX_W{1'b0}};
         duty_q   <= {MIX_W{1'b0}};
         acc_q    <= {MIX_W{1'b0}};
         mode_q   <= MODE_PWM;
         pwm_q    <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         duty_q   <= duty_d;
         acc_q    <= acc_d;
         mode_q   <= mode_d;
         pwm_q    <= pwm_d;
         strobe_q <= strobe_d;
      end
   end

endmodule
